// File: rtl/io_bus_ctrl.sv
// Memory-mapped IO controller: registered output channels, synchronised and debounced
// input channels, per-channel write strobes and sticky change flags. Macro IO_DEBOUNCE_EN builds the debounce counters.
module io_bus_ctrl #(
  parameter int unsigned       DATA_W          = 24,
  parameter int unsigned       NUM_CH          = 4,
  parameter logic [21:0]       BASE_HI         = 22'h3FFFFF,
  parameter int unsigned       SYNC_STAGES     = 2,
  parameter int unsigned       DEBOUNCE_CYCLES = 16,
  parameter logic [DATA_W-1:0] OUT_RST         = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              io_addr,
  input  logic                     io_ren,
  input  logic                     io_wen,
  input  logic [31:0]              io_wdata,
  output logic [31:0]              io_rdata,
  output logic                     io_hit,
  input  logic [NUM_CH*DATA_W-1:0] in_pins,
  output logic [NUM_CH*DATA_W-1:0] out_pins,
  output logic [NUM_CH-1:0]        wr_pulse,
  output logic [NUM_CH-1:0]        chg_flags
);

  localparam int unsigned     CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    RGN_IN,
    RGN_STAT,
    RGN_OUT
  } region_e;

  // Channel k occupies bits [k*DATA_W +: DATA_W], matching the pin buses.
  typedef logic [NUM_CH-1:0][DATA_W-1:0] chan_vec_t;

  region_e           region;
  logic [CH_W-1:0]   idx;
  logic              idx_ok;
  logic              wr_en;
  logic [NUM_CH-1:0] wr_onehot;
  logic [NUM_CH-1:0] rd_clr;
  logic [NUM_CH-1:0] chg_set;
  logic [NUM_CH-1:0] wr_pulse_q;
  logic [NUM_CH-1:0] chg_q;
  logic [31:0]       status_word;
  logic              unused_bits;

  chan_vec_t out_q;
  chan_vec_t sync_q [SYNC_STAGES];
  chan_vec_t syncd;
  chan_vec_t stable_q;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign io_hit = (io_addr[31:10] == BASE_HI);
  assign idx    = io_addr[2 +: CH_W];
  assign idx_ok = ({1'b0, idx} < NUM_CH_V);

  always_comb begin
    case (io_addr[9:8])
      2'b00:   region = RGN_IN;
      2'b01:   region = RGN_STAT;
      default: region = RGN_OUT;
    endcase
  end

  assign wr_en = io_wen && io_hit && (region == RGN_OUT) && idx_ok;

  // idx == k already implies idx < NUM_CH, so no range check is needed here.
  always_comb begin
    wr_onehot = '0;
    rd_clr    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      wr_onehot[k] = wr_en && (idx == CH_W'(k));
      rd_clr[k]    = io_ren && io_hit && (region == RGN_IN) && (idx == CH_W'(k));
    end
  end

  // ---------------------------------------------------------------------------
  // Output channels and write strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q      <= {NUM_CH{OUT_RST}};
      wr_pulse_q <= '0;
    end else begin
      // NOTE: non-blocking so a same-cycle read of this channel sees the old value,
      // exactly as the flops do; blocking here would make simulation disagree with silicon.
      if (wr_en) out_q[idx] <= io_wdata[DATA_W-1:0];
      wr_pulse_q <= wr_onehot;
    end
  end

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: this array is a bank of flops, not a RAM, so every entry is reset;
      // a true memory array would be left without reset.
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in_pins;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign syncd = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce / acceptance of new input values
  // ---------------------------------------------------------------------------
`ifdef IO_DEBOUNCE_EN
  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [NUM_CH];

  always_comb begin
    chg_set = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      chg_set[k] = (syncd[k] != stable_q[k]) && (cnt_q[k] == CNT_LAST);
    end
  end

  // Any return to the stable value before the threshold restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (syncd[k] == stable_q[k]) begin
          cnt_q[k] <= '0;
        end else if (chg_set[k]) begin
          stable_q[k] <= syncd[k];
          cnt_q[k]    <= '0;
        end else begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end
`else
  logic unused_deb;
  assign unused_deb = ^(32'(DEBOUNCE_CYCLES));

  always_comb begin
    chg_set = '0;
    for (int k = 0; k < NUM_CH; k++) chg_set[k] = (syncd[k] != stable_q[k]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stable_q <= '0;
    else       stable_q <= syncd;
  end
`endif

  // Set has priority over a read-clear landing on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) chg_q <= '0;
    else       chg_q <= (chg_q & ~rd_clr) | chg_set;
  end

  // ---------------------------------------------------------------------------
  // Read mux: registers only, never a pin-to-bus path
  // ---------------------------------------------------------------------------
  if (NUM_CH <= 32) begin : g_stat_narrow
    assign status_word = 32'(chg_q);
  end else begin : g_stat_wide
    assign status_word = chg_q[31:0];
  end

  always_comb begin
    io_rdata = '0;
    if (io_hit) begin
      case (region)
        RGN_IN:   if (idx_ok) io_rdata = 32'(stable_q[idx]);
        RGN_STAT: io_rdata = status_word;
        RGN_OUT:  if (idx_ok) io_rdata = 32'(out_q[idx]);
        default:  io_rdata = '0;
      endcase
    end
  end

  assign out_pins    = out_q;
  assign wr_pulse    = wr_pulse_q;
  assign chg_flags   = chg_q;
  assign unused_bits = ^{io_addr, io_wdata};

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed self-checking bench for io_bus_ctrl at default parameters
// (DATA_W=24, NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=16, OUT_RST=0).
module tb_io_bus_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] io_addr;
  logic        io_ren;
  logic        io_wen;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_hit;
  logic [95:0] in_pins;
  logic [95:0] out_pins;
  logic [3:0]  wr_pulse;
  logic [3:0]  chg_flags;

  int total;
  int bad;

  io_bus_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .io_addr   (io_addr),
    .io_ren    (io_ren),
    .io_wen    (io_wen),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .io_hit    (io_hit),
    .in_pins   (in_pins),
    .out_pins  (out_pins),
    .wr_pulse  (wr_pulse),
    .chg_flags (chg_flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    io_addr  = '0;
    io_ren   = 1'b0;
    io_wen   = 1'b0;
    io_wdata = '0;
    in_pins  = '0;
    #12 reset = 1'b0;
    edges(1);

    // Reset state
    io_addr = 32'hFFFFFD00;
    #1;
    check("rst_hit",    io_hit,    1);
    check("rst_status", io_rdata,  0);
    check("rst_out",    out_pins,  0);
    check("rst_pulse",  wr_pulse,  0);
    check("rst_flags",  chg_flags, 0);

    // Write channel 0, then reset asynchronously mid-cycle
    io_addr  = 32'hFFFFFE00;
    io_wdata = 32'h00123456;
    io_wen   = 1'b1;
    edges(1);
    io_wen = 1'b0;
    check("pre_arst_out",   out_pins, {72'h0, 24'h123456});
    check("pre_arst_pulse", wr_pulse, 4'b0001);
    #2 reset = 1'b1;
    #1;
    io_addr = 32'hFFFFFD00;
    #1;
    check("arst_out",    out_pins,  0);
    check("arst_pulse",  wr_pulse,  0);
    check("arst_flags",  chg_flags, 0);
    check("arst_status", io_rdata,  0);
    reset = 1'b0;
    edges(1);

    // Write/readback on channel 2; upper wdata bits are discarded
    io_addr  = 32'hFFFFFE08;
    io_wdata = 32'hFFABCDEF;
    io_wen   = 1'b1;
    #1;
    check("rd_during_wr_old", io_rdata, 0);
    edges(1);
    io_wen = 1'b0;
    check("wr_out",   out_pins, 96'h000000_ABCDEF_000000_000000);
    check("wr_pulse", wr_pulse, 4'b0100);
    check("wr_rdback", io_rdata, 32'h00ABCDEF);
    edges(1);
    check("wr_pulse_once", wr_pulse, 4'b0000);

    // Dropped writes: no hit, input region, status region
    io_wen   = 1'b1;
    io_wdata = 32'h00FFFFFF;
    io_addr  = 32'h00000E04;
    #1;
    check("nohit_hit",   io_hit,   0);
    check("nohit_rdata", io_rdata, 0);
    edges(1);
    io_addr = 32'hFFFFFC04;
    edges(1);
    io_addr = 32'hFFFFFD00;
    edges(1);
    io_wen = 1'b0;
    check("drop_out",   out_pins, 96'h000000_ABCDEF_000000_000000);
    check("drop_pulse", wr_pulse, 4'b0000);

    // With four channels the index field is io_addr[3:2], so 0xFFFFFE10 aliases channel 0
    io_addr  = 32'hFFFFFE10;
    io_wdata = 32'h00777777;
    io_wen   = 1'b1;
    edges(1);
    io_wen = 1'b0;
    check("alias_out",   out_pins, 96'h000000_ABCDEF_000000_777777);
    check("alias_pulse", wr_pulse, 4'b0001);

`ifdef IO_DEBOUNCE_EN
    // Debounce accept on channel 1: value appears at edge 18
    io_addr = 32'hFFFFFC04;
    in_pins[1*24 +: 24] = 24'h000055;
    edges(17);
    check("deb_e17_rdata", io_rdata,  0);
    check("deb_e17_flags", chg_flags, 0);
    edges(1);
    check("deb_e18_rdata", io_rdata,  32'h00000055);
    check("deb_e18_flags", chg_flags, 4'b0010);

    // Status read leaves the flag, input read clears it
    io_addr = 32'hFFFFFD00;
    io_ren  = 1'b1;
    #1;
    check("deb_status", io_rdata, 32'h2);
    edges(1);
    check("deb_stat_noclr", chg_flags, 4'b0010);
    io_addr = 32'hFFFFFC04;
    edges(1);
    check("deb_clr", chg_flags, 4'b0000);

    // Read held on channel 1 while a new value is accepted: set wins
    in_pins[1*24 +: 24] = 24'h0000AA;
    edges(17);
    check("deb_sc_e17", chg_flags, 4'b0000);
    edges(1);
    check("deb_sc_set",   chg_flags, 4'b0010);
    check("deb_sc_rdata", io_rdata,  32'h000000AA);
    edges(1);
    check("deb_sc_clr", chg_flags, 4'b0000);
    io_ren = 1'b0;

    // Bounce on channel 0 bit 0 every 5 cycles is rejected
    io_addr = 32'hFFFFFC00;
    for (int t = 0; t < 20; t++) begin
      in_pins[0] = ~in_pins[0];
      edges(5);
    end
    check("bounce_rdata", io_rdata,  0);
    check("bounce_flags", chg_flags, 0);
`else
    // Channel 3 change reaches io_rdata after 3 edges
    io_addr = 32'hFFFFFC0C;
    in_pins[3*24 +: 24] = 24'h5A5A5A;
    edges(2);
    check("nd_e2_rdata", io_rdata,  0);
    check("nd_e2_flags", chg_flags, 0);
    edges(1);
    check("nd_e3_rdata", io_rdata,  32'h005A5A5A);
    check("nd_e3_flags", chg_flags, 4'b1000);

    // Status read leaves the flag, input read clears it
    io_addr = 32'hFFFFFD00;
    io_ren  = 1'b1;
    #1;
    check("nd_status", io_rdata, 32'h8);
    edges(1);
    check("nd_stat_noclr", chg_flags, 4'b1000);
    io_addr = 32'hFFFFFC0C;
    edges(1);
    check("nd_clr", chg_flags, 4'b0000);

    // Read held on channel 1 while a change is accepted: set wins, then clears
    io_addr = 32'hFFFFFC04;
    in_pins[1*24 +: 24] = 24'h000055;
    edges(2);
    check("nd_sc_e2", chg_flags, 4'b0000);
    edges(1);
    check("nd_sc_set",   chg_flags, 4'b0010);
    check("nd_sc_rdata", io_rdata,  32'h00000055);
    edges(1);
    check("nd_sc_clr", chg_flags, 4'b0000);
    io_ren = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
